// File: rtl/mac_seq_pkg.sv
// Shared defaults and FSM state encoding for the MAC sequencer.
package mac_seq_pkg;

    localparam int MAC_A_W   = 17;
    localparam int MAC_W_W   = 8;
    localparam int MAC_ACC_W = 32;
    localparam int MAC_LEN_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_core.sv
// Registered signed multiply-accumulate: load seeds the accumulator, ce adds a*b.
module mac_core
    import mac_seq_pkg::*;
#(
    parameter int A_W   = MAC_A_W,
    parameter int W_W   = MAC_W_W,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    ce,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [W_W-1:0]   b,
    input  logic signed [ACC_W-1:0] seed,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+W_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   r_acc;

    assign w_prod     = a * b;
    // Sign-extending cast; the sum below wraps modulo 2^ACC_W.
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= seed;
        end else if (ce) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: paired activation/weight streams into mac_core.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_LOAD  | seed acc with bias, load remaining count
//   ST_ACCUM | consume operand pairs until count reaches zero
//   ST_OUT   | present result until res_ready
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int A_W   = MAC_A_W,
    parameter int W_W   = MAC_W_W,
    parameter int ACC_W = MAC_ACC_W,
    parameter int LEN_W = MAC_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [ACC_W-1:0] bias,
    output logic             busy,
    input  logic             act_valid,
    input  logic [A_W-1:0]   act_data,
    output logic             act_ready,
    input  logic             wt_valid,
    input  logic [W_W-1:0]   wt_data,
    output logic             wt_ready,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    input  logic             res_ready
);

    mac_state_t        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_bias;
    logic              w_accum;
    logic              w_fire;
    logic              w_load;
    logic [ACC_W-1:0]  w_seed;
    logic [ACC_W-1:0]  w_acc;

    assign w_accum   = (r_state == ST_ACCUM);
    assign act_ready = w_accum & wt_valid;
    assign wt_ready  = w_accum & act_valid;
    assign w_fire    = w_accum & act_valid & wt_valid & ~abort;
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_OUT);
    assign res_data  = res_valid ? w_acc : '0;

    // Abort reuses the load path with a zero seed to discard the accumulator.
    assign w_load = (r_state == ST_LOAD) | abort;
    assign w_seed = abort ? '0 : r_bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_bias  <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len   <= cfg_len;
                        r_bias  <= bias;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= r_len;
                    r_state <= (r_len != '0) ? ST_ACCUM : ST_OUT;
                end
                ST_ACCUM: begin
                    if (w_fire) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mac_core #(
        .A_W   (A_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .ce    (w_fire),
        .a     (act_data),
        .b     (wt_data),
        .seed  (w_seed),
        .acc   (w_acc)
    );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: hand-computed dot products, stalls, abort and reset.
module tb_mac_seq_ctrl;

    localparam int A_W   = 17;
    localparam int W_W   = 8;
    localparam int ACC_W = 32;
    localparam int LEN_W = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [ACC_W-1:0] bias = '0;
    logic             busy;
    logic             act_valid = 1'b0;
    logic [A_W-1:0]   act_data = '0;
    logic             act_ready;
    logic             wt_valid = 1'b0;
    logic [W_W-1:0]   wt_data = '0;
    logic             wt_ready;
    logic             res_valid;
    logic [ACC_W-1:0] res_data;
    logic             res_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    mac_seq_ctrl #(
        .A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_len(cfg_len), .bias(bias), .busy(busy),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [ACC_W-1:0] b);
        cfg_len = len;
        bias    = b;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic pair(input int a, input int w);
        act_data = A_W'(a);
        wt_data  = W_W'(w);
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    int         fires;
    int         idx;
    int         budget;
    logic [7:0] wpat;
    int         pa [4];
    int         pw [4];

    initial begin
        // reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_act_ready", 64'(act_ready), 64'd0);
        chk("rst_wt_ready", 64'(wt_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        rst_n = 1'b1;
        step();

        // bias 10, (2,3),(-4,5),(7,-1) -> -11
        act_valid = 1'b1;
        wt_valid  = 1'b1;
        start_job(9'd3, 32'd10);
        chk("t1_load_busy", 64'(busy), 64'd1);
        chk("t1_load_act_ready", 64'(act_ready), 64'd0);
        step();
        chk("t1_accum_act_ready", 64'(act_ready), 64'd1);
        chk("t1_accum_wt_ready", 64'(wt_ready), 64'd1);
        pair(2, 3);   step();
        pair(-4, 5);  step();
        pair(7, -1);
        chk("t1_no_early_res", 64'(res_valid), 64'd0);
        step();
        chk("t1_res_valid", 64'(res_valid), 64'd1);
        chk("t1_res_data", 64'(res_data), 64'hFFFF_FFF5);
        chk("t1_out_act_ready", 64'(act_ready), 64'd0);
        take_result();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_res_valid", 64'(res_valid), 64'd0);

        // cfg_len 0, bias -5: result two cycles after start, no ready pulses
        start_job(9'd0, 32'hFFFF_FFFB);
        chk("t2_load_act_ready", 64'(act_ready), 64'd0);
        chk("t2_load_res_valid", 64'(res_valid), 64'd0);
        step();
        chk("t2_res_valid", 64'(res_valid), 64'd1);
        chk("t2_res_data", 64'(res_data), 64'hFFFF_FFFB);
        chk("t2_out_wt_ready", 64'(wt_ready), 64'd0);
        take_result();

        // wrap: 0x7FFFFFFF + 1*1
        start_job(9'd1, 32'h7FFF_FFFF);
        step();
        pair(1, 1);
        step();
        chk("t3_wrap", 64'(res_data), 64'h8000_0000);
        take_result();

        // extreme operands: -65536 * -128 = 8388608
        start_job(9'd1, 32'd0);
        step();
        pair(-65536, -128);
        step();
        chk("t3_extreme", 64'(res_data), 64'd8388608);
        take_result();

        // weight stream stalls; act_valid held: 2+12-30+56 = 40
        pa[0] = 1;  pw[0] = 2;
        pa[1] = 3;  pw[1] = 4;
        pa[2] = -5; pw[2] = 6;
        pa[3] = 7;  pw[3] = 8;
        wpat   = 8'b1011_0010;
        wt_valid = 1'b0;
        start_job(9'd4, 32'd0);
        step();
        idx = 0; fires = 0; budget = 0;
        while (idx < 4 && budget < 40) begin
            wt_valid = wpat[budget % 8];
            pair(pa[idx], pw[idx]);
            #1;
            chk("t4_act_ready_eq_wt_valid", 64'(act_ready), 64'(wt_valid));
            chk("t4_wt_ready", 64'(wt_ready), 64'd1);
            if (act_valid && act_ready && wt_valid && wt_ready) fires++;
            step();
            if (wt_valid) idx++;
            budget++;
        end
        wt_valid = 1'b0;
        chk("t4_pairs_consumed", 64'(fires), 64'd4);
        chk("t4_res_valid", 64'(res_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("t4_res_stable", 64'(res_data), 64'd40);
            step();
        end
        chk("t4_res_held_valid", 64'(res_valid), 64'd1);
        take_result();

        // abort after 2 of 4 pairs, then bias 1 + 3*3 = 10
        wt_valid = 1'b1;
        start_job(9'd4, 32'd100);
        step();
        pair(1, 1); step();
        pair(1, 1); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_res_valid", 64'(res_valid), 64'd0);
        step();
        chk("t5_abort_stays_idle", 64'(res_valid), 64'd0);
        act_valid = 1'b1;
        wt_valid  = 1'b1;
        start_job(9'd1, 32'd1);
        step();
        pair(3, 3);
        step();
        chk("t5_after_abort", 64'(res_data), 64'd10);
        take_result();

        // reset mid-ACCUM with streams stalled
        act_valid = 1'b0;
        wt_valid  = 1'b0;
        start_job(9'd3, 32'd7);
        step(); step(); step();
        chk("t6_stall_busy", 64'(busy), 64'd1);
        chk("t6_stall_res_valid", 64'(res_valid), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_accum_busy", 64'(busy), 64'd0);
        chk("t6_rst_accum_ready", 64'({act_ready, wt_ready}), 64'd0);
        #1 rst_n = 1'b1;
        step();
        chk("t6_post_rst_busy", 64'(busy), 64'd0);

        // reset mid-OUT
        start_job(9'd0, 32'd55);
        step();
        chk("t6_out_reached", 64'(res_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(res_valid), 64'd0);
        chk("t6_rst_out_data", 64'(res_data), 64'd0);
        #1 rst_n = 1'b1;
        step(); step();
        chk("t6_no_result_after_rst", 64'(res_valid), 64'd0);

        act_valid = 1'b1;
        wt_valid  = 1'b1;
        start_job(9'd1, 32'd1);
        step();
        pair(3, 3);
        step();
        chk("t6_job_after_rst", 64'(res_data), 64'd10);
        take_result();
        chk("t6_final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter A_W, default 17, activation operand width (signed).
REQ-002 Parameter W_W, default 8, weight operand width (signed).
REQ-003 Parameter ACC_W, default 32, accumulator/result width (signed).
REQ-004 Parameter LEN_W, default 9, width of cfg_len; max dot-product length 2^LEN_W-1.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle job request; sampled only in IDLE.
REQ-009 abort  in  1  synchronous job cancel, any state.
REQ-010 cfg_len  in  LEN_W  number of operand pairs for the job; captured on accepted start.
REQ-011 bias  in  ACC_W  signed accumulator seed; captured on accepted start.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 act_valid / act_data  in  1 / A_W  activation stream.
REQ-014 act_ready  out  1  activation accept.
REQ-015 wt_valid / wt_data  in  1 / W_W  weight stream.
REQ-016 wt_ready  out  1  weight accept.
REQ-017 res_valid / res_data  out  1 / ACC_W  result stream; res_ready  in  1  downstream accept.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, ACCUM, OUT.
REQ-019 IDLE->LOAD on start; cfg_len and bias registered that cycle; start outside IDLE ignored.
REQ-020 LOAD SHALL last exactly one cycle: acc<=bias, remaining count<=cfg_len; ->ACCUM if cfg_len!=0, else ->OUT.
REQ-021 In ACCUM: act_ready = act_valid-independent? no -- act_ready = ACCUM & wt_valid; wt_ready = ACCUM & act_valid; a pair fires only when both valid in ACCUM; single-sided transfers SHALL never occur.
REQ-022 On pair fire: acc <= acc + sext(act_data*wt_data); remaining count decrements by 1.
REQ-023 Zero operand (either act_data==0 or wt_data==0) SHALL leave acc unchanged but still count as a pair.
REQ-024 Product is full A_W+W_W bit signed, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W (no saturation).
REQ-025 When the firing pair is the last (count==1), ->OUT; res_valid SHALL assert the next cycle with the final acc (1-cycle latency from last pair).
REQ-026 In OUT: res_valid=1, res_data=acc held stable until res_ready; on res_valid&res_ready ->IDLE; start in that same cycle ignored.
REQ-027 abort SHALL force IDLE next cycle from any state, deassert res_valid, discard acc; abort has priority over start, pair fire and result handshake.
REQ-028 act_ready, wt_ready SHALL be 0 outside ACCUM; input streams stalled indefinitely leave state and acc unchanged.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, busy=0, act_ready=0, wt_ready=0, res_valid=0, res_data=0, acc=0, count=0.
REQ-030 Reset asserted mid-job SHALL discard the job; no result emitted after release.
REQ-031 First start SHALL be accepted no earlier than the first rising edge after rst_n deassertion.

Structure
REQ-032 Package mac_seq_pkg SHALL hold A_W/W_W/ACC_W/LEN_W defaults and the FSM state enum.
REQ-033 Sub-module mac_core SHALL hold the registered accumulator: inputs load, ce, a, b, seed; output acc; same async active-low reset.
REQ-034 FSM, counter and handshake logic SHALL live in mac_seq_ctrl.

Verification
REQ-035 bias=10, cfg_len=3, pairs (2,3),(-4,5),(7,-1), both streams always valid -> res_data=-11, res_valid 1 cycle after third pair, busy low after handshake.
REQ-036 cfg_len=0, bias=-5 -> res_valid 2 cycles after start with res_data=-5, no act/wt ready pulses.
REQ-037 bias=0x7FFFFFFF, cfg_len=1, pair (1,1) -> res_data=0x80000000 (wrap); pair (-65536,-128) with bias 0 -> 8388608.
REQ-038 cfg_len=4, wt_valid toggled randomly, act_valid held -> no single-sided transfer, exactly 4 pairs consumed, correct sum; res_ready held low 5 cycles -> res_data stable.
REQ-039 abort asserted after 2 of 4 pairs -> IDLE next cycle, no res_valid; following job bias=1, cfg_len=1, (3,3) -> res_data=10.
REQ-040 rst_n pulsed low mid-ACCUM and mid-OUT -> all outputs zero asynchronously; subsequent job correct.
